// File: rtl/tile_pkg.sv
// tile_pkg: shared constants and helpers for the tile FIFO and its
// consumers.
//   TILE_DATA_W / TILE_SIZE : default element width and tile edge.
//   count_width(depth)      : bits needed to hold an occupancy of 0..depth.
package tile_pkg;

    localparam int TILE_DATA_W = 8;
    localparam int TILE_SIZE   = 2;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tile_transpose.sv
// tile_transpose: purely combinational SIZE x SIZE tile transpose.
//   tile_i : input tile, indexed [row][col]
//   tile_o : transposed tile, tile_o[r][c] = tile_i[c][r]
module tile_transpose #(
    parameter int DATA_W = 8,
    parameter int SIZE   = 2
) (
    input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] tile_i,
    output logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] tile_o
);

    for (genvar r = 0; r < SIZE; r++) begin : g_row
        for (genvar c = 0; c < SIZE; c++) begin : g_col
            assign tile_o[r][c] = tile_i[c][r];
        end
    end

endmodule

// File: rtl/tile_stream_fifo.sv
// tile_stream_fifo: queue of whole SIZE x SIZE tiles with an optional
// transpose-on-read tag per entry.
//   clk, rst_n      : clock (rising edge), async active-low reset
//   flush           : synchronous clear of contents and error flags
//   push, push_transpose, din : write side; tag selects transposed output
//   push_rdy        : space available
//   pop, pop_rdy    : read side request / data available
//   dout            : registered output tile, updated only on accepted pop
//   count           : entries held
//   almost_full     : count >= AF_LEVEL
//   almost_empty    : count <= AE_LEVEL
//   overflow        : sticky, push seen while full
//   underflow       : sticky, pop seen while empty
module tile_stream_fifo
    import tile_pkg::*;
#(
    parameter int DATA_W   = TILE_DATA_W,
    parameter int SIZE     = TILE_SIZE,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  push,
    input  logic                                  push_transpose,
    input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] din,
    output logic                                  push_rdy,
    input  logic                                  pop,
    output logic                                  pop_rdy,
    output logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] dout,
    output logic [count_width(DEPTH)-1:0]         count,
    output logic                                  almost_full,
    output logic                                  almost_empty,
    output logic                                  overflow,
    output logic                                  underflow
);

    localparam int CNT_W = count_width(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] tile_t;

    tile_t             mem_q [DEPTH];
    logic [DEPTH-1:0]  tag_q;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    tile_t             dout_q, dout_d;

    tile_t             rd_tile, rd_tile_t;
    logic              push_acc, pop_acc;

    // Pointers wrap explicitly at DEPTH-1, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push_rdy     = (count_q < CNT_W'(DEPTH));
    assign pop_rdy      = (count_q != '0);
    assign almost_full  = (int'(count_q) >= AF_LEVEL);
    assign almost_empty = (int'(count_q) <= AE_LEVEL);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign count        = count_q;
    assign dout         = dout_q;

    // Acceptance is judged on pre-edge occupancy: no pass-through when full,
    // no bypass when empty.
    assign push_acc = push && push_rdy;
    assign pop_acc  = pop && pop_rdy;

    assign rd_tile = mem_q[rd_ptr_q];

    tile_transpose #(.DATA_W(DATA_W), .SIZE(SIZE)) u_rd_transpose (
        .tile_i (rd_tile),
        .tile_o (rd_tile_t)
    );

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        dout_d   = dout_q;
        if (flush) begin
            // Flush wins over same-cycle requests; dout keeps the last tile.
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push && !push_rdy) ovf_d = 1'b1;
            if (pop && !pop_rdy)   udf_d = 1'b1;
            if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                dout_d   = tag_q[rd_ptr_q] ? rd_tile_t : rd_tile;
            end
            if (push_acc && !pop_acc)      count_d = count_q + 1'b1;
            else if (pop_acc && !push_acc) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is not reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (!flush && push_acc) begin
            mem_q[wr_ptr_q] <= din;
            tag_q[wr_ptr_q] <= push_transpose;
        end
    end

endmodule

// File: tb/tb_tile_stream_fifo.sv
module tb_tile_stream_fifo;

    localparam int DW = 8;
    localparam int SZ = 2;
    localparam int DP = 3;

    typedef logic [SZ-1:0][SZ-1:0][DW-1:0] tile_t;

    typedef struct {
        logic  fl, pu, po, tp;
        tile_t din;
        int    cnt;
        logic  ov, ud;
        tile_t dout;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0, push = 1'b0, push_transpose = 1'b0, pop = 1'b0;
    tile_t       din = '0;
    logic        push_rdy, pop_rdy, almost_full, almost_empty, overflow, underflow;
    tile_t       dout;
    logic [1:0]  count;

    int passed = 0;
    int total  = 0;

    tile_stream_fifo #(.DATA_W(DW), .SIZE(SZ), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .push(push),
        .push_transpose(push_transpose), .din(din), .push_rdy(push_rdy),
        .pop(pop), .pop_rdy(pop_rdy), .dout(dout), .count(count),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic tile_t mk(input int a, input int b, input int c, input int d);
        tile_t t;
        t[0][0] = 8'(a); t[0][1] = 8'(b); t[1][0] = 8'(c); t[1][1] = 8'(d);
        return t;
    endfunction

    function automatic vec_t V(input logic fl, input logic pu, input logic po, input logic tp,
                               input tile_t d, input int cnt, input logic ov, input logic ud,
                               input tile_t q);
        vec_t v;
        v.fl = fl; v.pu = pu; v.po = po; v.tp = tp; v.din = d;
        v.cnt = cnt; v.ov = ov; v.ud = ud; v.dout = q;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
        else passed++;
    endtask

    // Status flags are checked against the documented formulas for DEPTH=3,
    // AF_LEVEL=2, AE_LEVEL=1.
    task automatic chk_all(input int idx, input int cnt, input logic ov, input logic ud, input tile_t q);
        chk("count",        idx, 32'(count),        32'(cnt));
        chk("push_rdy",     idx, 32'(push_rdy),     32'(cnt < DP));
        chk("pop_rdy",      idx, 32'(pop_rdy),      32'(cnt != 0));
        chk("almost_full",  idx, 32'(almost_full),  32'(cnt >= 2));
        chk("almost_empty", idx, 32'(almost_empty), 32'(cnt <= 1));
        chk("overflow",     idx, 32'(overflow),     32'(ov));
        chk("underflow",    idx, 32'(underflow),    32'(ud));
        chk("dout",         idx, dout,              q);
    endtask

    task automatic drive(input logic fl, input logic pu, input logic po, input logic tp, input tile_t d);
        @(negedge clk);
        flush = fl; push = pu; pop = po; push_transpose = tp; din = d;
        @(posedge clk);
        #1;
        flush = 1'b0; push = 1'b0; pop = 1'b0; push_transpose = 1'b0;
    endtask

    vec_t vt[$];

    initial begin
        tile_t A, B, C, D, E, Z, X, Y, L, M, S, N0;
        A = mk(11,12,13,14); B = mk(21,22,23,24); C = mk(31,32,33,34);
        D = mk(11,12,21,22); E = mk(41,42,43,44);
        L = mk(111,112,113,114); M = mk(121,122,123,124); S = mk(1,2,3,4);
        N0 = '0;

        // FIFO order and full/empty status
        vt.push_back(V(0,1,0,0, A, 1, 0,0, N0));
        vt.push_back(V(0,1,0,0, B, 2, 0,0, N0));
        vt.push_back(V(0,1,0,0, C, 3, 0,0, N0));
        vt.push_back(V(0,0,1,0, N0, 2, 0,0, A));
        vt.push_back(V(0,0,1,0, N0, 1, 0,0, B));
        vt.push_back(V(0,0,1,0, N0, 0, 0,0, C));
        // transpose tag, then untagged tile
        vt.push_back(V(0,1,0,1, D, 1, 0,0, C));
        vt.push_back(V(0,1,0,0, E, 2, 0,0, C));
        vt.push_back(V(0,0,1,0, N0, 1, 0,0, mk(11,21,12,22)));
        vt.push_back(V(0,0,1,0, N0, 0, 0,0, E));
        // steady push+pop at count 2 across pointer wrap
        vt.push_back(V(0,1,0,0, mk(51,52,53,54), 1, 0,0, E));
        vt.push_back(V(0,1,0,0, mk(61,62,63,64), 2, 0,0, E));
        vt.push_back(V(0,1,1,0, mk(71,72,73,74), 2, 0,0, mk(51,52,53,54)));
        vt.push_back(V(0,1,1,0, mk(81,82,83,84), 2, 0,0, mk(61,62,63,64)));
        vt.push_back(V(0,1,1,0, mk(91,92,93,94), 2, 0,0, mk(71,72,73,74)));
        vt.push_back(V(0,1,1,0, mk(101,102,103,104), 2, 0,0, mk(81,82,83,84)));
        vt.push_back(V(0,1,1,0, L, 2, 0,0, mk(91,92,93,94)));
        vt.push_back(V(0,0,1,0, N0, 1, 0,0, mk(101,102,103,104)));
        vt.push_back(V(0,0,1,0, N0, 0, 0,0, L));
        // underflow on empty pop, then overflow when full
        vt.push_back(V(0,0,1,0, N0, 0, 0,1, L));
        vt.push_back(V(0,1,1,0, M, 1, 0,1, L));
        vt.push_back(V(0,1,0,0, mk(131,132,133,134), 2, 0,1, L));
        vt.push_back(V(0,1,0,0, mk(141,142,143,144), 3, 0,1, L));
        vt.push_back(V(0,1,0,0, mk(151,152,153,154), 3, 1,1, L));
        vt.push_back(V(0,1,1,0, mk(161,162,163,164), 2, 1,1, M));
        // flush beats same-cycle push/pop and clears the flags
        vt.push_back(V(1,1,1,0, mk(171,172,173,174), 0, 0,0, M));
        vt.push_back(V(0,0,0,0, N0, 0, 0,0, M));
        vt.push_back(V(0,1,0,0, S, 1, 0,0, M));
        vt.push_back(V(0,0,1,0, N0, 0, 0,0, S));

        // reset state, during reset and after idling
        #12;
        chk_all(1000, 0, 0, 0, N0);
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_all(1001, 0, 0, 0, N0);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].fl, vt[i].pu, vt[i].po, vt[i].tp, vt[i].din);
            chk_all(i, vt[i].cnt, vt[i].ov, vt[i].ud, vt[i].dout);
        end

        // asynchronous reset mid-stream, applied away from any clock edge
        X = mk(201,202,203,204); Y = mk(211,212,213,214);
        drive(0,1,0,0, X);
        drive(0,1,0,0, Y);
        drive(0,0,1,0, N0);
        chk_all(2000, 1, 0, 0, X);
        @(negedge clk); #2; rst_n = 1'b0; #1;
        chk_all(2001, 0, 0, 0, N0);
        @(negedge clk); rst_n = 1'b1;

        // empty with push+pop: push taken, pop rejected as underflow
        Z = mk(221,222,223,224);
        drive(0,1,1,1, Z);
        chk_all(2002, 1, 0, 1, N0);
        drive(0,0,1,0, N0);
        chk_all(2003, 0, 0, 1, mk(221,223,222,224));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
